execute_muldiv: RTL and testbench
=================================

# execute_muldiv

Parametrised execute stage for the pipelined RV32IM core. It sits between the ID/EX and EX/MEM pipeline registers and provides operand forwarding, the single-cycle ALU path, and a full branch comparator with JALR targets. It also contains an iterative multiply/divide unit covering the RV32M funct3 set, which stalls the pipeline through a busy handshake with the hazard unit.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width; even, ≥ 8
- REG_FILE_ADDRESS_WIDTH, 5, register index width; pass-through only, no logic depends on it

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- ValidE  in  1  a real (non-bubble) instruction is in E
- FlushE  in  1  synchronous abort of any mul/div in flight
- JumpE, JalrE, BranchE  in  1 each  control from decode
- BranchTypeE  in  3  funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
- ALUControlE  in  4  existing ALU encoding
- ALUSrcE  in  1  SrcB = ExtImmE when 1
- MulDivE  in  1  instruction is RV32M
- MulDivOpE  in  3  funct3: mul, mulh, mulhsu, mulhu, div, divu, rem, remu
- RD1E, RD2E, PCE, ExtImmE, ResultW, ALUResultM  in  DATA_WIDTH each
- ForwardAE, ForwardBE  in  2 each  forwarding select: 00 RD, 01 ResultW, 10 ALUResultM, 11 zero
- PCSrcE  out  1  redirect fetch
- PCTargetE  out  DATA_WIDTH  branch/jump target
- ALUResultE  out  DATA_WIDTH  ALU or mul/div result
- WriteDataE  out  DATA_WIDTH  forwarded rs2
- BusyE  out  1  stall request to the hazard unit

## Operation
- SrcA = fwd(RD1E, ForwardAE). WriteDataE = fwd(RD2E, ForwardBE). SrcB = ALUSrcE ? ExtImmE : WriteDataE.
- Branch condition uses SrcA against WriteDataE: eq, ne, signed lt/ge, unsigned lt/ge. Undefined BranchTypeE codes mean not taken.
- PCSrcE = ValidE & (JumpE | (BranchE & cond)).
- PCTargetE = JalrE ? ((SrcA + ExtImmE) & ~1) : (PCE + ExtImmE).
- ALUResultE = ALU(SrcA, SrcB) when MulDivE = 0. When MulDivE = 1, it is the latched mul/div result in state DONE and don't-care otherwise.
- FSM states are IDLE, BUSY and DONE.
  - IDLE: start = ValidE & MulDivE & ~FlushE. On start, latch |SrcA| and |WriteDataE| (abs only for signed ops), result signs and op, then clear the counter.
  - From IDLE, a divisor of zero or signed overflow (MIN / -1) goes to DONE. Any other start goes to BUSY.
  - BUSY: one radix-2 step per cycle; shift-add for multiply, restoring for divide. Go to DONE when counter = DATA_WIDTH-1.
  - DONE: present the sign-corrected result, then return to IDLE unconditionally. DONE never restarts, even though the same instruction is still in E.
  - FlushE in BUSY or DONE returns the FSM to IDLE. No result is produced.
- Multiply: 2·DATA_WIDTH-bit product.
  - mul returns the low half. mulh, mulhsu and mulhu return the high half.
  - mulhsu treats only SrcA as signed.
- Divide: quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Special cases:
  - Divide by zero: quotient is all ones, remainder is the dividend.
  - Signed overflow: quotient is MIN, remainder is 0.
- BusyE = ~rst & ((IDLE & start) | BUSY). It is combinational, so the hazard unit freezes F/D/E and bubbles M in the start cycle itself.

## Timing
- Async rst: state IDLE, counter 0, internal registers 0. BusyE = 0 while rst is high. All other outputs are combinational from inputs.
- Forwarding, ALU and branch paths have zero latency, with the result valid in the same cycle.
- Normal mul/div holds E for DATA_WIDTH+2 cycles: 1 start cycle, DATA_WIDTH BUSY cycles, 1 DONE cycle. That is 34 cycles at width 32.
- Special-case divides take 2 cycles: start, then DONE.
- BusyE is low in DONE, so the pipeline advances on the clock edge that ends DONE.
- Back-to-back mul/div: the next instruction arrives in IDLE and starts on its first cycle.
- Operands are captured at start. Later changes on ResultW, ALUResultM or the forward selects during BUSY have no effect.
- rst during BUSY aborts immediately. The result is lost and BusyE drops asynchronously.

## Test plan
- Forwarding: RD1E=1, ALUResultM=5, ForwardAE=10, add with imm 3 -> ALUResultE=8. Then ForwardAE=11 -> 3.
- Branches: blt with SrcA=0xFFFFFFFF, WriteDataE=1 -> PCSrcE=1. bltu with the same operands -> 0. JALR with SrcA=0x1001, imm 2 -> PCTargetE=0x1002.
- mulh 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000. mulhu with the same operands -> 0xFFFFFFFE.
  - Both with BusyE high for exactly 33 cycles and result in cycle 34.
- div -7/2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF. divu 7/0 -> 0xFFFFFFFF in 2 cycles. div 0x80000000/-1 -> 0x80000000, rem 0.
- Back-to-back mul then div: the second starts in the cycle after DONE, with no lost or duplicated start.
- Reset at BUSY cycle 10 -> BusyE=0 immediately and state IDLE. Next mul completes normally.
- FlushE at BUSY cycle 5 -> IDLE next edge, with no DONE.

Source files
------------

// File: rtl/execute_muldiv.sv
// Execute stage: operand forwarding, ALU, branch compare/targets, and an iterative
// radix-2 multiply/divide unit that stalls the pipeline through BusyE.
module execute_muldiv #(
  parameter int unsigned DATA_WIDTH             = 32,
  parameter int unsigned REG_FILE_ADDRESS_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidE,
  input  logic                  FlushE,
  input  logic                  JumpE,
  input  logic                  JalrE,
  input  logic                  BranchE,
  input  logic [2:0]            BranchTypeE,
  input  logic [3:0]            ALUControlE,
  input  logic                  ALUSrcE,
  input  logic                  MulDivE,
  input  logic [2:0]            MulDivOpE,
  input  logic [DATA_WIDTH-1:0] RD1E,
  input  logic [DATA_WIDTH-1:0] RD2E,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] ExtImmE,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  output logic                  PCSrcE,
  output logic [DATA_WIDTH-1:0] PCTargetE,
  output logic [DATA_WIDTH-1:0] ALUResultE,
  output logic [DATA_WIDTH-1:0] WriteDataE,
  output logic                  BusyE
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned LogW = $clog2(DATA_WIDTH);

  localparam logic [W-1:0] MinVal    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] AlignMask = {{(W-1){1'b1}}, 1'b0};

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluAnd   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluXor   = 4'd4;
  localparam logic [3:0] AluSlt   = 4'd5;
  localparam logic [3:0] AluSltu  = 4'd6;
  localparam logic [3:0] AluSll   = 4'd7;
  localparam logic [3:0] AluSrl   = 4'd8;
  localparam logic [3:0] AluSra   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  if (DATA_WIDTH < 8 || (DATA_WIDTH % 2) != 0 || REG_FILE_ADDRESS_WIDTH == 0) begin : g_param_check
    $error("execute_muldiv: unsupported parameter values");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Forwarding and operand selection
  logic [W-1:0] src_a, src_b;

  always_comb begin
    unique case (ForwardAE)
      2'b00:   src_a = RD1E;
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = '0;
    endcase
    unique case (ForwardBE)
      2'b00:   WriteDataE = RD2E;
      2'b01:   WriteDataE = ResultW;
      2'b10:   WriteDataE = ALUResultM;
      default: WriteDataE = '0;
    endcase
  end

  assign src_b = ALUSrcE ? ExtImmE : WriteDataE;

  // Branch comparator and targets
  logic         br_eq, br_lt, br_ltu, br_cond;
  logic [W-1:0] jalr_sum;

  assign br_eq  = (src_a == WriteDataE);
  assign br_lt  = ($signed(src_a) < $signed(WriteDataE));
  assign br_ltu = (src_a < WriteDataE);

  always_comb begin
    br_cond = 1'b0;
    case (BranchTypeE)
      3'b000:  br_cond = br_eq;
      3'b001:  br_cond = ~br_eq;
      3'b100:  br_cond = br_lt;
      3'b101:  br_cond = ~br_lt;
      3'b110:  br_cond = br_ltu;
      3'b111:  br_cond = ~br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign PCSrcE    = ValidE & (JumpE | (BranchE & br_cond));
  assign jalr_sum  = src_a + ExtImmE;
  assign PCTargetE = JalrE ? (jalr_sum & AlignMask) : (PCE + ExtImmE);

  // Single-cycle ALU
  logic [W-1:0]    alu_res;
  logic [LogW-1:0] shamt;

  assign shamt = src_b[LogW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      AluAdd:   alu_res = src_a + src_b;
      AluSub:   alu_res = src_a - src_b;
      AluAnd:   alu_res = src_a & src_b;
      AluOr:    alu_res = src_a | src_b;
      AluXor:   alu_res = src_a ^ src_b;
      AluSlt:   alu_res = {{(W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      AluSltu:  alu_res = {{(W-1){1'b0}}, (src_a < src_b)};
      AluSll:   alu_res = src_a << shamt;
      AluSrl:   alu_res = src_a >> shamt;
      AluSra:   alu_res = $signed(src_a) >>> shamt;
      AluPassB: alu_res = src_b;
      default:  alu_res = '0;
    endcase
  end

  // Multiply/divide unit
  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [LogW-1:0] cnt_q, cnt_d;

  logic         start, signed_a, signed_b, sign_a, sign_b, div_zero, div_ovf;
  logic [W-1:0] abs_a, abs_b, spec_quo, spec_rem;

  assign start    = ValidE & MulDivE & ~FlushE;
  assign signed_a = MulDivOpE[2] ? ~MulDivOpE[0] : (MulDivOpE[1:0] != 2'b11);
  assign signed_b = MulDivOpE[2] ? ~MulDivOpE[0] : ~MulDivOpE[1];
  assign sign_a   = signed_a & src_a[W-1];
  assign sign_b   = signed_b & WriteDataE[W-1];
  assign abs_a    = sign_a ? -src_a : src_a;
  assign abs_b    = sign_b ? -WriteDataE : WriteDataE;
  assign div_zero = MulDivOpE[2] & (WriteDataE == '0);
  assign div_ovf  = MulDivOpE[2] & ~MulDivOpE[0] & (src_a == MinVal) & (&WriteDataE);
  // Special cases are stored already in final form, so their sign flag stays clear.
  assign spec_quo = div_zero ? '1 : MinVal;
  assign spec_rem = div_zero ? src_a : '0;

  // Multiply: prod_q = {partial product high, multiplier being shifted out}.
  logic [W-1:0]   mul_addend;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;

  assign mul_addend = prod_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, prod_q[2*W-1:W]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, prod_q[W-1:1]};

  // Divide: prod_q = {partial remainder, dividend shifting into quotient}.
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  logic [2*W-1:0] div_next;

  assign div_shift = {prod_q[2*W-1:W], prod_q[W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[W-1:0] - opnd_q;
  assign div_next  = {(div_ge ? div_diff : div_shift[W-1:0]), prod_q[W-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = MulDivOpE;
          cnt_d = '0;
          if (MulDivOpE[2]) begin
            opnd_d = abs_b;
            neg_d  = MulDivOpE[1] ? sign_a : (sign_a ^ sign_b);
            prod_d = {{W{1'b0}}, abs_a};
          end else begin
            opnd_d = abs_a;
            neg_d  = sign_a ^ sign_b;
            prod_d = {{W{1'b0}}, abs_b};
          end
          if (div_zero || div_ovf) begin
            neg_d   = 1'b0;
            prod_d  = {spec_rem, spec_quo};
            state_d = StDone;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (FlushE) begin
          state_d = StIdle;
        end else begin
          prod_d = op_q[2] ? div_next : mul_next;
          cnt_d  = cnt_q + LogW'(1);
          if (cnt_q == LogW'(W - 1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sign correction: multiply negates the full product, divide negates the chosen half.
  logic [2*W-1:0] md_full;
  logic [W-1:0]   md_half, md_res;

  assign md_full = neg_q ? -prod_q : prod_q;
  assign md_half = op_q[1] ? prod_q[2*W-1:W] : prod_q[W-1:0];
  assign md_res  = op_q[2] ? (neg_q ? -md_half : md_half)
                 : ((op_q[1:0] == 2'b00) ? md_full[W-1:0] : md_full[2*W-1:W]);

  assign ALUResultE = MulDivE ? md_res : alu_res;
  assign BusyE      = ~rst & (((state_q == StIdle) & start) | (state_q == StBusy));

endmodule

// File: tb/tb_execute_muldiv.sv
// Randomised and directed bench for execute_muldiv against an arithmetic reference model.
module tb_execute_muldiv;

  logic        clk, rst;
  logic        ValidE, FlushE, JumpE, JalrE, BranchE, ALUSrcE, MulDivE;
  logic [2:0]  BranchTypeE, MulDivOpE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ExtImmE, ResultW, ALUResultM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE, BusyE;
  logic [31:0] PCTargetE, ALUResultE, WriteDataE;

  int n_cmp = 0;
  int n_bad = 0;

  execute_muldiv #(.DATA_WIDTH(32), .REG_FILE_ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE), .JumpE(JumpE), .JalrE(JalrE),
    .BranchE(BranchE), .BranchTypeE(BranchTypeE), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE), .RD1E(RD1E), .RD2E(RD2E),
    .PCE(PCE), .ExtImmE(ExtImmE), .ResultW(ResultW), .ALUResultM(ALUResultM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .BusyE(BusyE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd_m(input logic [31:0] rd, input logic [1:0] sel,
                                        input logic [31:0] rw, input logic [31:0] am);
    case (sel)
      2'd0:    return rd;
      2'd1:    return rw;
      2'd2:    return am;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu_m(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return 32'(sa >>> b[4:0]);
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_m(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (t)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] md_m(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    longint      la, lb, lub;
    logic [63:0] p;
    int          ia, ib;
    logic        ovf;
    la  = longint'($signed(a));
    lb  = longint'($signed(b));
    lub = longint'({32'd0, b});
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = la * lb; return p[31:0]; end
      3'd1: begin p = la * lb; return p[63:32]; end
      3'd2: begin p = la * lub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Total cycles the instruction occupies E, start cycle through DONE.
  function automatic int md_dur(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 34;
  endfunction

  // ---------------- compare process ----------------
  int          md_left = 0;
  logic [31:0] md_exp;

  always @(negedge clk) begin
    logic [31:0] a, wd, b, tgt;
    if (rst) begin
      md_left = 0;
      check("busy_in_reset", 32'(BusyE), 32'd0);
    end else begin
      a   = fwd_m(RD1E, ForwardAE, ResultW, ALUResultM);
      wd  = fwd_m(RD2E, ForwardBE, ResultW, ALUResultM);
      b   = ALUSrcE ? ExtImmE : wd;
      tgt = JalrE ? ((a + ExtImmE) & ~32'd1) : (PCE + ExtImmE);
      check("write_data", WriteDataE, wd);
      check("pc_target", PCTargetE, tgt);
      check("pc_src", 32'(PCSrcE), 32'(ValidE & (JumpE | (BranchE & br_m(BranchTypeE, a, wd)))));
      if (!MulDivE) check("alu_result", ALUResultE, alu_m(ALUControlE, a, b));
      if (md_left == 0) begin
        if (ValidE && MulDivE && !FlushE) begin
          md_exp  = md_m(MulDivOpE, a, wd);
          md_left = md_dur(MulDivOpE, a, wd) - 1;
          check("busy_start", 32'(BusyE), 32'd1);
        end else begin
          check("busy_idle", 32'(BusyE), 32'd0);
        end
      end else begin
        check("busy_run", 32'(BusyE), 32'(md_left > 1));
        if (md_left == 1 && !FlushE) check("md_result_model", ALUResultE, md_exp);
        if (FlushE) md_left = 0;
        else md_left--;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ValidE = 0; FlushE = 0; JumpE = 0; JalrE = 0; BranchE = 0; ALUSrcE = 0; MulDivE = 0;
    ForwardAE = 0; ForwardBE = 0; BranchTypeE = 3'b010; ALUControlE = 4'd0;
  endtask

  task automatic set_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    set_idle();
    ValidE = 1; MulDivE = 1; MulDivOpE = op; RD1E = a; RD2E = b;
  endtask

  // Called at posedge+1; holds the instruction until DONE, returns at posedge+1 after it.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int busy_cycles);
    logic done;
    set_md(op, a, b);
    busy_cycles = 0;
    done = 0;
    res = 32'd0;
    for (int i = 0; i < 100 && !done; i++) begin
      settle();
      if (BusyE) busy_cycles++;
      else begin
        done = 1;
        res  = ALUResultE;
      end
      next();
      if (!done) begin
        // Captured operands must ignore these.
        ResultW = $urandom; ALUResultM = $urandom;
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL md_timeout: op %0d still busy after 100 cycles", op);
    end else begin
      check("md_busy_cycles", 32'(busy_cycles), 32'(md_dur(op, a, b) - 1));
      check("md_result", res, md_m(op, a, b));
    end
    set_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] res;
    int          bc;
    logic [31:0] ra, rb;

    rst = 1;
    set_idle();
    RD1E = 0; RD2E = 0; PCE = 0; ExtImmE = 0; ResultW = 0; ALUResultM = 0; MulDivOpE = 0;
    ValidE = 1; MulDivE = 1;
    settle();
    check("reset_busy_low", 32'(BusyE), 32'd0);
    set_idle();
    settle();
    #1 rst = 0;
    next();

    // Forwarding into the ALU
    ValidE = 1; RD1E = 1; ALUResultM = 5; ForwardAE = 2'b10; ALUSrcE = 1; ExtImmE = 3;
    settle();
    check("fwd_alum_add", ALUResultE, 32'd8);
    next();
    ForwardAE = 2'b11;
    settle();
    check("fwd_zero_add", ALUResultE, 32'd3);
    next();

    // Branches and JALR
    set_idle();
    ValidE = 1; RD1E = 32'hFFFF_FFFF; RD2E = 1; BranchE = 1; BranchTypeE = 3'b100;
    settle();
    check("blt_taken", 32'(PCSrcE), 32'd1);
    next();
    BranchTypeE = 3'b110;
    settle();
    check("bltu_not_taken", 32'(PCSrcE), 32'd0);
    next();
    set_idle();
    ValidE = 1; JumpE = 1; JalrE = 1; RD1E = 32'h1001; ExtImmE = 2;
    settle();
    check("jalr_target", PCTargetE, 32'h1002);
    check("jalr_redirect", 32'(PCSrcE), 32'd1);
    next();
    set_idle();

    // Multiply/divide literals
    run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, bc);
    check("mulh_lit", res, 32'h0);
    check("mulh_busy33", 32'(bc), 32'd33);
    run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, bc);
    check("mulhu_lit", res, 32'hFFFF_FFFE);
    check("mulhu_busy33", 32'(bc), 32'd33);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, res, bc);
    check("div_neg7_2", res, 32'hFFFF_FFFD);
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2, res, bc);
    check("rem_neg7_2", res, 32'hFFFF_FFFF);
    run_md(3'd5, 32'd7, 32'd0, res, bc);
    check("divu_by_zero", res, 32'hFFFF_FFFF);
    check("divu_by_zero_busy1", 32'(bc), 32'd1);
    run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, res, bc);
    check("div_overflow", res, 32'h8000_0000);
    check("div_overflow_busy1", 32'(bc), 32'd1);
    run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, res, bc);
    check("rem_overflow", res, 32'h0);

    // Back-to-back mul then div
    run_md(3'd0, 32'd12345, 32'd678, res, bc);
    check("b2b_mul", res, 32'h007F_B6F6);
    run_md(3'd4, 32'd1000, 32'hFFFF_FFF9, res, bc);
    check("b2b_div", res, 32'hFFFF_FF72);
    check("b2b_div_busy33", 32'(bc), 32'd33);

    // Flush in BUSY
    set_md(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (5) next();
    FlushE = 1;
    settle();
    check("flush_cycle_busy", 32'(BusyE), 32'd1);
    next();
    run_md(3'd4, 32'd100, 32'd7, res, bc);
    check("after_flush_div", res, 32'd14);
    check("after_flush_busy33", 32'(bc), 32'd33);

    // Reset in BUSY
    set_md(3'd0, 32'h1111_1111, 32'h2222_2222);
    repeat (10) next();
    settle();
    #2 rst = 1;
    #1 check("reset_drops_busy", 32'(BusyE), 32'd0);
    set_idle();
    settle();
    #1 rst = 0;
    next();
    run_md(3'd0, 32'd7, 32'd6, res, bc);
    check("after_reset_mul", res, 32'd42);
    check("after_reset_busy33", 32'(bc), 32'd33);

    // Random mix
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        ValidE = 1'($urandom); FlushE = 1'($urandom); JumpE = 1'($urandom);
        JalrE = 1'($urandom); BranchE = 1'($urandom); BranchTypeE = 3'($urandom);
        ALUControlE = 4'($urandom_range(0, 10)); ALUSrcE = 1'($urandom); MulDivE = 0;
        RD1E = $urandom; RD2E = $urandom; PCE = $urandom; ExtImmE = $urandom;
        ResultW = $urandom; ALUResultM = $urandom;
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
        settle();
        next();
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          set_md(3'($urandom), $urandom, $urandom);
          ValidE = 1'($urandom);
          FlushE = ValidE;
          settle();
          next();
        end
        case ($urandom_range(0, 3))
          0:       ra = 32'h8000_0000;
          1:       ra = 32'($urandom_range(0, 50)) - 32'd25;
          default: ra = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0:       rb = 32'd0;
          1:       rb = 32'hFFFF_FFFF;
          2:       rb = 32'($urandom_range(1, 9));
          default: rb = $urandom;
        endcase
        run_md(3'($urandom), ra, rb, res, bc);
      end
    end
    set_idle();
    settle();
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
